fetch_unit: RTL and testbench

- Instruction-fetch stage that sits directly upstream of the control decoder.
- Holds the program counter and drives the instruction-memory address. Presents the 9-bit instruction to the decoder.
- Consumes the decoder's pc_jmp_en and 4-bit LUT pointer to redirect the PC through a 16-entry jump-target LUT.
- Owns the start/done handshake with the testbench/top level, halt detection and a run-cycle counter.

---
 rtl/fetch_pkg.sv | 22 ++
 rtl/jump_lut.sv | 31 +++
 rtl/fetch_unit.sv | 119 +++++++++++
 tb/tb_fetch_unit.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch stage and the downstream control decoder.
// Holds the widths, the halt/NOP encodings and the fetch FSM state type.
package fetch_pkg;

    localparam int INSTR_W   = 9;
    localparam int LUT_PTR_W = 4;
    localparam int LUT_DEPTH = 1 << LUT_PTR_W;

    localparam logic [5:0]         HALT_OP   = 6'b111111;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 9'b111111000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/jump_lut.sv
// 16-entry jump-target register file: one combinational read port and one
// clocked write port. A same-cycle read of the written index sees the old entry.
module jump_lut
    import fetch_pkg::*;
#(
    parameter int PC_W = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_we,
    input  logic [LUT_PTR_W-1:0] i_waddr,
    input  logic [PC_W-1:0]      i_wdata,
    input  logic [LUT_PTR_W-1:0] i_raddr,
    output logic [PC_W-1:0]      o_rdata
);

    logic [PC_W-1:0] r_mem [LUT_DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < LUT_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, start/done handshake, halt detection, jump
// redirection through jump_lut and a saturating count of executed RUN cycles.
//
// state   | meaning
// IDLE    | waiting for start, pc parked at START_ADDR, NOP to decoder
// RUN     | fetching/executing, instr follows imem_data unless stalled
// DONE    | halt seen, pc parked on halt address, done asserted
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              PC_W       = 10,
    parameter logic [PC_W-1:0] START_ADDR = '0,
    parameter logic [5:0]      HALT_OP    = fetch_pkg::HALT_OP
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 stall,
    input  logic                 pc_jmp_en,
    input  logic [LUT_PTR_W-1:0] lut_ptr,
    input  logic                 lut_we,
    input  logic [LUT_PTR_W-1:0] lut_waddr,
    input  logic [PC_W-1:0]      lut_wdata,
    output logic [PC_W-1:0]      imem_addr,
    input  logic [INSTR_W-1:0]   imem_data,
    output logic [INSTR_W-1:0]   instr,
    output logic                 running,
    output logic                 done,
    output logic [15:0]          cycle_count
);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_pc_nxt;
    logic [15:0]     r_cycle_count;
    logic [15:0]     w_cnt_nxt;
    logic            r_running;
    logic            r_done;
    logic [PC_W-1:0] w_jmp_target;
    logic            w_halt;

    jump_lut #(
        .PC_W (PC_W)
    ) u_jump_lut (
        .clk     (clk),
        .reset   (reset),
        .i_we    (lut_we),
        .i_waddr (lut_waddr),
        .i_wdata (lut_wdata),
        .i_raddr (lut_ptr),
        .o_rdata (w_jmp_target)
    );

    assign w_halt = (imem_data[8:3] == HALT_OP);

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_cnt_nxt   = r_cycle_count;
        instr       = NOP_INSTR;
        case (r_state)
            ST_IDLE: begin
                w_pc_nxt = START_ADDR;
                if (start) begin
                    w_state_nxt = ST_RUN;
                    w_cnt_nxt   = '0;
                end
            end
            ST_RUN: begin
                // Stall masks the instruction so the decoder sees no side effects.
                if (!stall) begin
                    instr     = imem_data;
                    w_cnt_nxt = sat_inc16(r_cycle_count);
                    if (w_halt) begin
                        w_state_nxt = ST_DONE;
                    end else if (pc_jmp_en) begin
                        w_pc_nxt = w_jmp_target;
                    end else begin
                        w_pc_nxt = r_pc + PC_W'(1);
                    end
                end
            end
            ST_DONE: begin
                if (start) begin
                    w_state_nxt = ST_RUN;
                    w_pc_nxt    = START_ADDR;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_pc_nxt    = START_ADDR;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_pc          <= START_ADDR;
            r_cycle_count <= '0;
            r_running     <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_cycle_count <= w_cnt_nxt;
            r_running     <= (w_state_nxt == ST_RUN);
            r_done        <= (w_state_nxt == ST_DONE);
        end
    end

    assign imem_addr   = r_pc;
    assign running     = r_running;
    assign done        = r_done;
    assign cycle_count = r_cycle_count;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: linear run, jumps, LUT collision, stall,
// reset mid-run, PC wrap and cycle counter saturation.
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam logic [8:0] HALT_I = 9'b111111101;
    localparam logic [8:0] NOP_I  = 9'b111111000;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        stall;
    logic        pc_jmp_en;
    logic [3:0]  lut_ptr;
    logic        lut_we;
    logic [3:0]  lut_waddr;
    logic [9:0]  lut_wdata;
    logic [9:0]  imem_addr;
    logic [8:0]  imem_data;
    logic [8:0]  instr;
    logic        running;
    logic        done;
    logic [15:0] cycle_count;

    logic [8:0]  imem_mem [0:1023];

    int total = 0;
    int bad   = 0;

    fetch_unit dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .stall       (stall),
        .pc_jmp_en   (pc_jmp_en),
        .lut_ptr     (lut_ptr),
        .lut_we      (lut_we),
        .lut_waddr   (lut_waddr),
        .lut_wdata   (lut_wdata),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .instr       (instr),
        .running     (running),
        .done        (done),
        .cycle_count (cycle_count)
    );

    always #5 clk = ~clk;

    assign imem_data = imem_mem[imem_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        for (int i = 0; i < 1024; i++) imem_mem[i] = 9'h000;
        imem_mem[5] = HALT_I;
        reset = 1'b1; start = 1'b0; stall = 1'b0; pc_jmp_en = 1'b0;
        lut_ptr = '0; lut_we = 1'b0; lut_waddr = '0; lut_wdata = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_pc", imem_addr, 0);
        chk("rst_running", running, 0);
        chk("rst_done", done, 0);
        chk("rst_count", cycle_count, 0);
        chk("rst_instr", instr, NOP_I);
        reset = 1'b0;
        tick();
        chk("idle_instr", instr, NOP_I);

        // linear run to halt at 5
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("lin_pc0", imem_addr, 0);
        chk("lin_running", running, 1);
        chk("lin_count0", cycle_count, 0);
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk("lin_pc", imem_addr, i);
            chk("lin_count", cycle_count, i);
        end
        chk("lin_halt_instr", instr, HALT_I);
        chk("lin_not_done", done, 0);
        tick();
        chk("done_flag", done, 1);
        chk("done_running", running, 0);
        chk("done_pc", imem_addr, 5);
        chk("done_count", cycle_count, 6);
        chk("done_instr", instr, NOP_I);

        // LUT loads while in DONE
        lut_we = 1'b1; lut_waddr = 4'd3; lut_wdata = 10'd20;
        tick();
        lut_waddr = 4'd5; lut_wdata = 10'd7;
        tick();
        lut_we = 1'b0;
        imem_mem[5] = 9'h000;
        chk("done_hold_pc", imem_addr, 5);
        chk("done_hold", done, 1);

        // restart from DONE, jump through lut[3]
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("rs_pc0", imem_addr, 0);
        chk("rs_count0", cycle_count, 0);
        chk("rs_done", done, 0);
        chk("rs_running", running, 1);
        tick();
        tick();
        chk("jmp_pre_pc", imem_addr, 2);
        pc_jmp_en = 1'b1; lut_ptr = 4'd3;
        tick();
        chk("jmp_pc20", imem_addr, 20);
        pc_jmp_en = 1'b0;
        tick();
        chk("jmp_pc21", imem_addr, 21);

        // write and read of lut[5] in the same cycle
        lut_we = 1'b1; lut_waddr = 4'd5; lut_wdata = 10'd9;
        pc_jmp_en = 1'b1; lut_ptr = 4'd5;
        tick();
        chk("coll_old", imem_addr, 7);
        lut_we = 1'b0;
        tick();
        chk("coll_new", imem_addr, 9);
        chk("coll_count", cycle_count, 6);

        // stall with a pending jump: everything holds
        lut_ptr = 4'd3; stall = 1'b1;
        #1;
        chk("stall_instr0", instr, NOP_I);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_pc", imem_addr, 9);
            chk("stall_count", cycle_count, 6);
            chk("stall_instr", instr, NOP_I);
        end
        stall = 1'b0; pc_jmp_en = 1'b0;
        tick();
        chk("unstall_pc", imem_addr, 10);
        chk("unstall_count", cycle_count, 7);

        // start during RUN is ignored
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("run_start_pc", imem_addr, 11);
        chk("run_start_count", cycle_count, 8);
        tick();
        chk("pre_rst_pc", imem_addr, 12);

        // asynchronous reset mid-cycle
        reset = 1'b1;
        #1;
        chk("arst_pc", imem_addr, 0);
        chk("arst_running", running, 0);
        chk("arst_count", cycle_count, 0);
        chk("arst_done", done, 0);
        @(negedge clk);
        reset = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("post_rst_pc", imem_addr, 0);
        pc_jmp_en = 1'b1; lut_ptr = 4'd3;
        tick();
        chk("lut3_cleared", imem_addr, 0);
        lut_ptr = 4'd5;
        tick();
        chk("lut5_cleared", imem_addr, 0);
        chk("post_rst_count", cycle_count, 2);
        pc_jmp_en = 1'b0;

        // PC wrap at 1023
        n = 0;
        while (imem_addr !== 10'd1023 && n < 1100) begin
            tick();
            n++;
        end
        chk("reach_1023", imem_addr, 1023);
        tick();
        chk("wrap_pc0", imem_addr, 0);
        chk("wrap_running", running, 1);

        // counter saturation
        repeat (65600) @(posedge clk);
        #1;
        chk("sat_count", cycle_count, 16'hFFFF);
        imem_mem[imem_addr] = HALT_I;
        #1;
        chk("sat_halt_instr", instr, HALT_I);
        tick();
        chk("sat_done", done, 1);
        chk("sat_count_hold", cycle_count, 16'hFFFF);

        start = 1'b1;
        tick();
        start = 1'b0;
        chk("final_count0", cycle_count, 0);
        chk("final_pc0", imem_addr, 0);
        chk("final_running", running, 1);
        chk("final_done", done, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
